// File: rtl/fp_mul_mant_iter.sv
// Iterative radix-2 shift-add significand multiplier for single-precision products.
// Produces a normalized, truncated significand plus {L,R,S} bits for a downstream rounder.
module fp_mul_mant_iter (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        sign_a_i,
    input  logic        sign_b_i,
    input  logic [7:0]  exp_a_i,
    input  logic [7:0]  exp_b_i,
    input  logic [23:0] mant_a_i,
    input  logic [23:0] mant_b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        sign_O,
    output logic [9:0]  exp_o,
    output logic [23:0] mant_o,
    output logic [2:0]  LRS,
    output logic        zero_o
);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t      state, state_next;
    logic [4:0]  count;
    logic [47:0] acc;
    logic        sign_a, sign_b;
    logic [7:0]  exp_a, exp_b;
    logic [23:0] mant_a, mant_b;
    logic [47:0] addend;
    logic [9:0]  exp_sum;

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy_o     = (state != IDLE);
        done_o     = (state == DONE);
        case (state)
            IDLE: if (start_i) state_next = MUL;
            MUL:  if (count == 5'd23) state_next = NORM;
            NORM: state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign addend  = mant_b[count] ? ({24'd0, mant_a} << count) : 48'd0;
    assign exp_sum = {2'b00, exp_a} + {2'b00, exp_b};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count  <= '0;
            acc    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            exp_a  <= '0;
            exp_b  <= '0;
            mant_a <= '0;
            mant_b <= '0;
            sign_O <= 1'b0;
            exp_o  <= '0;
            mant_o <= '0;
            LRS    <= '0;
            zero_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        sign_a <= sign_a_i;
                        sign_b <= sign_b_i;
                        exp_a  <= exp_a_i;
                        exp_b  <= exp_b_i;
                        mant_a <= mant_a_i;
                        mant_b <= mant_b_i;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                MUL: begin
                    acc   <= acc + addend;
                    count <= count + 5'd1;
                end
                NORM: begin
                    sign_O <= sign_a ^ sign_b;
                    // A zero operand bypasses normalization entirely so the rounder sees a clean zero.
                    if (mant_a == 24'd0 || mant_b == 24'd0) begin
                        mant_o <= '0;
                        LRS    <= 3'b000;
                        exp_o  <= '0;
                        zero_o <= 1'b1;
                    end else if (acc[47]) begin
                        mant_o <= acc[47:24];
                        LRS    <= {acc[24], acc[23], |acc[22:0]};
                        exp_o  <= exp_sum - 10'd126;
                        zero_o <= 1'b0;
                    end else begin
                        mant_o <= acc[46:23];
                        LRS    <= {acc[23], acc[22], |acc[21:0]};
                        exp_o  <= exp_sum - 10'd127;
                        zero_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_mant_iter.sv
// Directed self-checking bench for fp_mul_mant_iter: latency, normalization, zero, start-ignore and reset-abort cases.
module tb_fp_mul_mant_iter;

    logic        clk_i = 1'b0;
    logic        reset_i, start_i, sign_a_i, sign_b_i;
    logic [7:0]  exp_a_i, exp_b_i;
    logic [23:0] mant_a_i, mant_b_i;
    logic        busy_o, done_o, sign_O, zero_o;
    logic [9:0]  exp_o;
    logic [23:0] mant_o;
    logic [2:0]  LRS;

    int total = 0;
    int bad   = 0;
    logic [23:0] lastMant = '0;

    fp_mul_mant_iter dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
        .sign_a_i(sign_a_i), .sign_b_i(sign_b_i),
        .exp_a_i(exp_a_i), .exp_b_i(exp_b_i),
        .mant_a_i(mant_a_i), .mant_b_i(mant_b_i),
        .busy_o(busy_o), .done_o(done_o), .sign_O(sign_O),
        .exp_o(exp_o), .mant_o(mant_o), .LRS(LRS), .zero_o(zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [47:0] observed, input logic [47:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string tag, input logic [23:0] m, input logic [9:0] e,
                               input logic [2:0] lrs, input logic s, input logic z);
        checkOutput({tag, "_mant"}, 48'(mant_o), 48'(m));
        checkOutput({tag, "_exp"},  48'(exp_o),  48'(e));
        checkOutput({tag, "_lrs"},  48'(LRS),    48'(lrs));
        checkOutput({tag, "_sign"}, 48'(sign_O), 48'(s));
        checkOutput({tag, "_zero"}, 48'(zero_o), 48'(z));
        lastMant = m;
    endtask

    // Launches one operation; inputs are scrambled after E0 to prove they are ignored.
    task automatic applyStimulus(input string tag, input logic sa, input logic sb,
                                 input logic [7:0] ea, input logic [7:0] eb,
                                 input logic [23:0] ma, input logic [23:0] mb,
                                 input int pulseAt, input int resetAt);
        int doneEdge = 0;
        int doneCount = 0;
        logic doneLate = 1'b0;
        sign_a_i = sa; sign_b_i = sb; exp_a_i = ea; exp_b_i = eb;
        mant_a_i = ma; mant_b_i = mb; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i  = 1'b0;
        sign_a_i = ~sa; sign_b_i = sb; exp_a_i = 8'h5A; exp_b_i = 8'hA5;
        mant_a_i = 24'h123456; mant_b_i = 24'h654321;
        checkOutput({tag, "_busy_e0"}, 48'(busy_o), 48'd1);
        for (int k = 1; k <= 26; k++) begin
            if (resetAt != 0 && k == resetAt) reset_i = 1'b1;
            @(posedge clk_i); #1;
            if (pulseAt != 0 && k == pulseAt - 1) start_i = 1'b1;
            if (pulseAt != 0 && k == pulseAt) start_i = 1'b0;
            if (resetAt != 0 && k == resetAt) begin
                reset_i = 1'b0;
                checkOutput({tag, "_rst_busy"}, 48'(busy_o), 48'd0);
                checkOutput({tag, "_rst_outs"}, {15'd0, sign_O, exp_o, mant_o, LRS, zero_o, done_o}, 48'd0);
                lastMant = '0;
            end
            if (k == 10) checkOutput({tag, "_hold_mid"}, 48'(mant_o), 48'(lastMant));
            if (done_o) doneCount++;
            if (done_o && doneEdge == 0) doneEdge = k;
            if (k == 26) doneLate = done_o;
        end
        if (resetAt != 0) begin
            for (int k = 0; k < 10; k++) begin
                @(posedge clk_i); #1;
                if (done_o) doneCount++;
            end
            checkOutput({tag, "_no_done"}, 48'(doneCount), 48'd0);
        end else begin
            checkOutput({tag, "_latency"}, 48'(doneEdge), 48'd25);
            checkOutput({tag, "_pulse"},   48'(doneCount), 48'd1);
            checkOutput({tag, "_done_drop"}, 48'(doneLate), 48'd0);
            checkOutput({tag, "_idle"}, 48'(busy_o), 48'd0);
        end
    endtask

    initial begin
        reset_i = 1'b1; start_i = 1'b0; sign_a_i = 1'b0; sign_b_i = 1'b0;
        exp_a_i = '0; exp_b_i = '0; mant_a_i = '0; mant_b_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("reset_outs", {15'd0, sign_O, exp_o, mant_o, LRS, zero_o, done_o, busy_o}, 48'd0);
        reset_i = 1'b0;
        @(posedge clk_i); #1;

        applyStimulus("unit", 1'b0, 1'b0, 8'd127, 8'd127, 24'h800000, 24'h800000, 0, 0);
        checkResult("unit", 24'h800000, 10'd127, 3'b000, 1'b0, 1'b0);

        // Started in the first IDLE cycle after DONE.
        applyStimulus("c1p5", 1'b0, 1'b1, 8'd127, 8'd127, 24'hC00000, 24'hC00000, 0, 0);
        checkResult("c1p5", 24'h900000, 10'd128, 3'b000, 1'b1, 1'b0);

        applyStimulus("tie", 1'b0, 1'b0, 8'd127, 8'd128, 24'h800001, 24'hC00000, 0, 0);
        checkResult("tie", 24'hC00001, 10'd128, 3'b110, 1'b0, 1'b0);

        applyStimulus("maxm", 1'b1, 1'b1, 8'd127, 8'd127, 24'hFFFFFF, 24'hFFFFFF, 0, 0);
        checkResult("maxm", 24'hFFFFFE, 10'd128, 3'b001, 1'b0, 1'b0);

        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("hold_idle", {22'd0, mant_o, LRS}, {22'd0, 24'hFFFFFE, 3'b001});

        applyStimulus("zero", 1'b1, 1'b0, 8'd100, 8'd50, 24'h000000, 24'hABCDEF, 10, 0);
        checkResult("zero", 24'h000000, 10'd0, 3'b000, 1'b1, 1'b1);

        // Exponent underflow wraps as 10-bit two's complement: 1+1-127 = -125.
        applyStimulus("uflow", 1'b0, 1'b0, 8'd1, 8'd1, 24'h800000, 24'h800000, 0, 0);
        checkResult("uflow", 24'h800000, 10'h383, 3'b000, 1'b0, 1'b0);

        applyStimulus("abort", 1'b1, 1'b0, 8'd127, 8'd127, 24'hC00000, 24'hC00000, 0, 12);

        applyStimulus("after", 1'b0, 1'b0, 8'd127, 8'd127, 24'h800000, 24'h800000, 0, 0);
        checkResult("after", 24'h800000, 10'd127, 3'b000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fp_mul_mant_iter.md
FP_MUL_MANT_ITER -- requirements
Module: fp_mul_mant_iter

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start_i  input  1  request; sampled only in IDLE.
REQ-004 SHALL have port sign_a_i, sign_b_i  input  1 each  operand signs.
REQ-005 SHALL have port exp_a_i, exp_b_i  input  8 each  biased exponents (bias 127).
REQ-006 SHALL have port mant_a_i, mant_b_i  input  24 each  significands with hidden bit at [23].
REQ-007 SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-008 SHALL have port done_o  output  1  one-cycle result-valid pulse.
REQ-009 SHALL have port sign_O  output  1  product sign, consumed by the rounder.
REQ-010 SHALL have port exp_o  output  10  signed two's-complement biased product exponent, unclamped.
REQ-011 SHALL have port mant_o  output  24  normalized truncated significand, [23] = leading one.
REQ-012 SHALL have port LRS  output  3  {L, R, S} = {mant_o LSB, round bit, sticky}, consumed by the rounder.
REQ-013 SHALL have port zero_o  output  1  product is exact zero.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, NORM, DONE.
REQ-015 IDLE with start_i=1 SHALL latch all operands, clear the 48-bit product accumulator and the 5-bit iteration counter, and go to MUL.
REQ-016 MUL SHALL do one radix-2 shift-add iteration per edge: add the latched mant_a, shifted by the counter, to the accumulator when bit[counter] of the latched mant_b is 1.
REQ-017 MUL SHALL run exactly 24 iterations (counter 0..23) and go to NORM on the edge that performs iteration 23.
REQ-018 NORM with P[47]=1 SHALL register mant_o=P[47:24], L=P[24], R=P[23], S=|P[22:0], exp_o=exp_a+exp_b-126.
REQ-019 NORM with P[47]=0 SHALL register mant_o=P[46:23], L=P[23], R=P[22], S=|P[21:0], exp_o=exp_a+exp_b-127.
REQ-020 NORM SHALL force mant_o=0, LRS=000, exp_o=0, zero_o=1 when either latched significand is 0; otherwise zero_o=0.
REQ-021 sign_O SHALL equal sign_a XOR sign_b latched at start, including for zero results.
REQ-022 Exponent arithmetic SHALL be 10-bit signed with no saturation; over/underflow detection is the consumer's job.
REQ-023 NORM SHALL move to DONE with done_o=1; DONE SHALL return to IDLE on the next edge with done_o=0.
REQ-024 Latency: the edge sampling start_i is E0; done_o SHALL be high for exactly the cycle following E25.
REQ-025 start_i SHALL be ignored in MUL, NORM and DONE; input changes after E0 SHALL NOT affect the result.
REQ-026 sign_O, exp_o, mant_o, LRS and zero_o SHALL update only in NORM and hold their value until the next NORM.
REQ-027 A start_i in the first IDLE cycle after DONE SHALL be accepted with the same 25-edge latency.

Reset
REQ-028 reset_i=1 at any edge SHALL force IDLE, counter=0, accumulator=0, busy_o=0, done_o=0, sign_O=0, exp_o=0, mant_o=0, LRS=000 and zero_o=0.
REQ-029 Reset SHALL take priority over start_i and abort an operation in progress with no done_o pulse.

Verification
REQ-030 mant 0x800000 x 0x800000, exps 127/127 -> mant_o=0x800000, exp_o=127, LRS=000, done_o after E25.
REQ-031 mant 0xC00000 x 0xC00000, exps 127/127, signs 0/1 -> mant_o=0x900000, exp_o=128, LRS=000, sign_O=1.
REQ-032 mant 0x800001 x 0xC00000, exps 127/128 -> mant_o=0xC00001, exp_o=128, LRS=110 (tie).
REQ-033 mant 0xFFFFFF x 0xFFFFFF, exps 127/127 -> mant_o=0xFFFFFE, exp_o=128, LRS=001.
REQ-034 mant_a=0, signs 1/0 -> zero_o=1, mant_o=0, LRS=000, exp_o=0, sign_O=1; a start_i pulse at E10 is ignored.
REQ-035 reset_i asserted at E12 of an operation -> IDLE on that edge, no done_o, all outputs 0; a new start_i then completes normally.
